step_counter: RTL and testbench

//   Parametrised successor of the fixed 8-bit odd counter: WIDTH-bit step counter

---
 rtl/step_counter_pkg.sv | 15 +
 rtl/step_counter_if.sv | 30 +++
 rtl/step_counter_next.sv | 44 ++++
 rtl/step_counter.sv | 58 +++++
 tb/tb_step_counter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_counter_pkg.sv
// step_counter shared types
// direction and overflow-mode encodings
package step_counter_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/step_counter_if.sv
// step_counter control/status bundle
// master drives controls, slave returns count and flags
interface step_counter_if #(
  parameter int WIDTH = 8
);
  import step_counter_pkg::*;

  logic             en_i;
  cnt_dir_e         dir_i;
  cnt_mode_e        mode_i;
  logic [WIDTH-1:0] step_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] cnt_o;
  logic             wrap_o;
  logic             sat_o;

  modport master (
    output en_i, dir_i, mode_i,
    output step_i, load_i, load_val_i,
    input  cnt_o, wrap_o, sat_o
  );

  modport slave (
    input  en_i, dir_i, mode_i,
    input  step_i, load_i, load_val_i,
    output cnt_o, wrap_o, sat_o
  );

endinterface

// File: rtl/step_counter_next.sv
// step_counter next-value datapath
// one step up/down with wrap or clamp
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] step,
  input  cnt_dir_e         dir,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             sat
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH:0] res;
  logic           ovf;

  // extra top bit carries the up-carry or down-borrow
  always_comb begin
    sum  = {1'b0, cnt} + {1'b0, step};
    dif  = {1'b0, cnt} - {1'b0, step};
    res  = (dir == CNT_DOWN) ? dif : sum;
    ovf  = res[WIDTH];
    nxt  = res[WIDTH-1:0];
    wrap = 1'b0;
    sat  = 1'b0;
    unique case (mode)
      CNT_WRAP: begin
        wrap = ovf;
      end
      CNT_SAT: begin
        if (ovf) begin
          nxt = (dir == CNT_UP) ? '1 : '0;
          sat = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/step_counter.sv
// step_counter top: count and flag registers
// priority reset > load > enable > hold
module step_counter
  import step_counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned RST_VAL = 1
) (
  input logic           clk,
  input logic           reset,
  step_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_V = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  logic             sat_q;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             nxt_sat;

  step_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cnt  (cnt_q),
    .step (bus.step_i),
    .dir  (bus.dir_i),
    .mode (bus.mode_i),
    .nxt  (nxt),
    .wrap (nxt_wrap),
    .sat  (nxt_sat)
  );

  // wrap is a one-cycle pulse; sat holds while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= RST_V;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (bus.load_i) begin
      cnt_q  <= bus.load_val_i;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (bus.en_i) begin
      cnt_q  <= nxt;
      wrap_q <= nxt_wrap;
      sat_q  <= nxt_sat;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.wrap_o = wrap_q;
  assign bus.sat_o  = sat_q;

endmodule

// File: tb/tb_step_counter.sv
// step_counter directed and randomised bench
// 8-bit instance for directed cases, 12-bit for random
module tb_step_counter;
  import step_counter_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  step_counter_if #(.WIDTH(8))  b8 ();
  step_counter_if #(.WIDTH(12)) b12 ();

  step_counter #(
    .WIDTH   (8),
    .RST_VAL (1)
  ) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  step_counter #(
    .WIDTH   (12),
    .RST_VAL (12'h7FF)
  ) u12 (
    .clk   (clk),
    .reset (reset),
    .bus   (b12.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b8.en_i = 1'b1;
    b8.dir_i = CNT_UP;
    b8.mode_i = CNT_WRAP;
    b8.step_i = 8'd2;
    b8.load_i = 1'b0;
    b8.load_val_i = 8'h00;
    b12.en_i = 1'b0;
    b12.dir_i = CNT_UP;
    b12.mode_i = CNT_WRAP;
    b12.step_i = 12'h000;
    b12.load_i = 1'b0;
    b12.load_val_i = 12'h000;
    reset = 1'b1;
    tick();
    tick();
    if (b8.cnt_o !== 8'h01 || b8.wrap_o !== 1'b0 || b8.sat_o !== 1'b0) begin
      $display("FAIL reset8: cnt=%h wrap=%b sat=%b want 01 0 0",
               b8.cnt_o, b8.wrap_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    if (b12.cnt_o !== 12'h7FF || b12.wrap_o !== 1'b0 || b12.sat_o !== 1'b0) begin
      $display("FAIL reset12: cnt=%h wrap=%b sat=%b want 7ff 0 0",
               b12.cnt_o, b12.wrap_o, b12.sat_o);
      n_fail++;
    end
    n_checks++;
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp;
    exp = 8'h01;
    for (int i = 0; i < 127; i++) begin
      tick();
      exp = exp + 8'd2;
      if (b8.cnt_o !== exp || b8.wrap_o !== 1'b0) begin
        $display("FAIL up_wrap step %0d: cnt=%h wrap=%b want %h 0",
                 i, b8.cnt_o, b8.wrap_o, exp);
        n_fail++;
      end
      n_checks++;
    end
    tick();
    if (b8.cnt_o !== 8'h01 || b8.wrap_o !== 1'b1) begin
      $display("FAIL up_wrap pulse: cnt=%h wrap=%b want 01 1",
               b8.cnt_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    tick();
    if (b8.cnt_o !== 8'h03 || b8.wrap_o !== 1'b0) begin
      $display("FAIL up_wrap after: cnt=%h wrap=%b want 03 0",
               b8.cnt_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_up_sat();
    b8.en_i = 1'b0;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'hFD;
    tick();
    if (b8.cnt_o !== 8'hFD || b8.sat_o !== 1'b0) begin
      $display("FAIL sat_load: cnt=%h sat=%b want fd 0", b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    b8.load_i = 1'b0;
    b8.en_i = 1'b1;
    b8.mode_i = CNT_SAT;
    b8.dir_i = CNT_UP;
    b8.step_i = 8'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b8.cnt_o !== 8'hFF || b8.sat_o !== 1'b1 || b8.wrap_o !== 1'b0) begin
        $display("FAIL sat_up %0d: cnt=%h sat=%b wrap=%b want ff 1 0",
                 i, b8.cnt_o, b8.sat_o, b8.wrap_o);
        n_fail++;
      end
      n_checks++;
    end
    b8.dir_i = CNT_DOWN;
    b8.step_i = 8'd2;
    tick();
    if (b8.cnt_o !== 8'hFD || b8.sat_o !== 1'b0) begin
      $display("FAIL sat_release: cnt=%h sat=%b want fd 0",
               b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_down();
    b8.en_i = 1'b0;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'h03;
    b8.mode_i = CNT_WRAP;
    tick();
    b8.load_i = 1'b0;
    b8.en_i = 1'b1;
    tick();
    if (b8.cnt_o !== 8'h01 || b8.wrap_o !== 1'b0) begin
      $display("FAIL down_1: cnt=%h wrap=%b want 01 0", b8.cnt_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    tick();
    if (b8.cnt_o !== 8'hFF || b8.wrap_o !== 1'b1) begin
      $display("FAIL down_wrap: cnt=%h wrap=%b want ff 1", b8.cnt_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    tick();
    if (b8.cnt_o !== 8'hFD || b8.wrap_o !== 1'b0) begin
      $display("FAIL down_after: cnt=%h wrap=%b want fd 0", b8.cnt_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    b8.en_i = 1'b0;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'h01;
    b8.mode_i = CNT_SAT;
    tick();
    b8.load_i = 1'b0;
    b8.en_i = 1'b1;
    tick();
    if (b8.cnt_o !== 8'h00 || b8.sat_o !== 1'b1 || b8.wrap_o !== 1'b0) begin
      $display("FAIL down_sat: cnt=%h sat=%b wrap=%b want 00 1 0",
               b8.cnt_o, b8.sat_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    b8.en_i = 1'b0;
    tick();
    if (b8.cnt_o !== 8'h00 || b8.sat_o !== 1'b1) begin
      $display("FAIL sat_hold: cnt=%h sat=%b want 00 1", b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'h02;
    tick();
    b8.load_i = 1'b0;
    b8.en_i = 1'b1;
    tick();
    if (b8.cnt_o !== 8'h00 || b8.sat_o !== 1'b0) begin
      $display("FAIL exact_zero: cnt=%h sat=%b want 00 0", b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_load_hold();
    b8.load_i = 1'b1;
    b8.load_val_i = 8'h40;
    b8.en_i = 1'b1;
    b8.dir_i = CNT_UP;
    b8.mode_i = CNT_WRAP;
    b8.step_i = 8'd2;
    tick();
    if (b8.cnt_o !== 8'h40 || b8.wrap_o !== 1'b0 || b8.sat_o !== 1'b0) begin
      $display("FAIL load_wins: cnt=%h wrap=%b sat=%b want 40 0 0",
               b8.cnt_o, b8.wrap_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    b8.load_i = 1'b0;
    b8.en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b8.cnt_o !== 8'h40) begin
        $display("FAIL hold %0d: cnt=%h want 40", i, b8.cnt_o);
        n_fail++;
      end
      n_checks++;
    end
    b8.en_i = 1'b1;
    b8.step_i = 8'd0;
    tick();
    if (b8.cnt_o !== 8'h40 || b8.wrap_o !== 1'b0 || b8.sat_o !== 1'b0) begin
      $display("FAIL step_zero: cnt=%h wrap=%b sat=%b want 40 0 0",
               b8.cnt_o, b8.wrap_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_async_reset();
    b8.en_i = 1'b0;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'hF0;
    tick();
    b8.load_i = 1'b0;
    b8.en_i = 1'b1;
    b8.mode_i = CNT_SAT;
    b8.dir_i = CNT_UP;
    b8.step_i = 8'h20;
    tick();
    if (b8.cnt_o !== 8'hFF || b8.sat_o !== 1'b1) begin
      $display("FAIL pre_reset: cnt=%h sat=%b want ff 1", b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    #2;
    reset = 1'b1;
    #1;
    if (b8.cnt_o !== 8'h01 || b8.sat_o !== 1'b0 || b8.wrap_o !== 1'b0) begin
      $display("FAIL async_reset: cnt=%h sat=%b wrap=%b want 01 0 0",
               b8.cnt_o, b8.sat_o, b8.wrap_o);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (b8.cnt_o !== 8'h01) begin
        $display("FAIL reset_hold %0d: cnt=%h want 01", i, b8.cnt_o);
        n_fail++;
      end
      n_checks++;
    end
    reset = 1'b0;
    tick();
    if (b8.cnt_o !== 8'h21 || b8.sat_o !== 1'b0) begin
      $display("FAIL first_after_reset: cnt=%h sat=%b want 21 0",
               b8.cnt_o, b8.sat_o);
      n_fail++;
    end
    n_checks++;
    b8.en_i = 1'b0;
  endtask

  task automatic test_random12();
    logic [11:0] m_cnt;
    logic        m_wrap;
    logic        m_sat;
    int unsigned c;
    int unsigned s;
    int unsigned k;
    logic        ovf;
    if (b12.cnt_o !== 12'h7FF) begin
      $display("FAIL w12_start: cnt=%h want 7ff", b12.cnt_o);
      n_fail++;
    end
    n_checks++;
    b12.en_i = 1'b1;
    b12.dir_i = CNT_UP;
    b12.mode_i = CNT_WRAP;
    b12.step_i = 12'h801;
    tick();
    if (b12.cnt_o !== 12'h000 || b12.wrap_o !== 1'b1) begin
      $display("FAIL w12_wrap: cnt=%h wrap=%b want 000 1",
               b12.cnt_o, b12.wrap_o);
      n_fail++;
    end
    n_checks++;
    m_cnt = 12'h000;
    m_wrap = 1'b1;
    m_sat = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      b12.load_i = ($urandom_range(0, 9) == 0);
      b12.load_val_i = 12'($urandom_range(0, 4095));
      b12.en_i = ($urandom_range(0, 4) != 0);
      b12.dir_i = ($urandom_range(0, 1) == 1) ? CNT_DOWN : CNT_UP;
      b12.mode_i = ($urandom_range(0, 1) == 1) ? CNT_SAT : CNT_WRAP;
      k = $urandom_range(0, 7);
      if (k == 0) b12.step_i = 12'h000;
      else if (k == 1) b12.step_i = 12'hFFF;
      else if (k == 2) b12.step_i = 12'($urandom_range(1, 3));
      else b12.step_i = 12'($urandom_range(0, 4095));
      c = m_cnt;
      s = b12.step_i;
      if (b12.load_i) begin
        m_cnt = b12.load_val_i;
        m_wrap = 1'b0;
        m_sat = 1'b0;
      end else if (b12.en_i) begin
        if (b12.dir_i == CNT_UP) begin
          ovf = (c + s > 4095);
          if (b12.mode_i == CNT_SAT) m_cnt = ovf ? 12'hFFF : 12'(c + s);
          else m_cnt = 12'((c + s) % 4096);
        end else begin
          ovf = (s > c);
          if (b12.mode_i == CNT_SAT) m_cnt = ovf ? 12'h000 : 12'(c - s);
          else m_cnt = ovf ? 12'(c + 4096 - s) : 12'(c - s);
        end
        m_wrap = ovf && (b12.mode_i == CNT_WRAP);
        m_sat = ovf && (b12.mode_i == CNT_SAT);
      end else begin
        m_wrap = 1'b0;
      end
      tick();
      if (b12.cnt_o !== m_cnt || b12.wrap_o !== m_wrap || b12.sat_o !== m_sat) begin
        $display("FAIL w12_rand %0d: cnt=%h wrap=%b sat=%b want %h %b %b",
                 i, b12.cnt_o, b12.wrap_o, b12.sat_o, m_cnt, m_wrap, m_sat);
        n_fail++;
      end
      n_checks++;
    end
    b12.en_i = 1'b0;
    b12.load_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    tick();
    if (b8.cnt_o !== 8'h03) begin
      $display("FAIL first_step: cnt=%h want 03", b8.cnt_o);
      n_fail++;
    end
    n_checks++;
    tick();
    if (b8.cnt_o !== 8'h05) begin
      $display("FAIL second_step: cnt=%h want 05", b8.cnt_o);
      n_fail++;
    end
    n_checks++;
    tick();
    if (b8.cnt_o !== 8'h07) begin
      $display("FAIL third_step: cnt=%h want 07", b8.cnt_o);
      n_fail++;
    end
    n_checks++;
    b8.load_i = 1'b1;
    b8.load_val_i = 8'h01;
    tick();
    b8.load_i = 1'b0;
    test_up_wrap();
    test_up_sat();
    test_down();
    test_load_hold();
    test_async_reset();
    test_random12();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
